// File: rtl/xcv5_icc_commit.sv
// ICC commit stage: aligns the cycle-0 ALU result with the cycle-1 flags and commits per-thread ICC.
// Optional macro ICC_FWD_EN enables the write-first bypass on the registered ICC read port.
module xcv5_icc_commit #(
    parameter int unsigned NTHREAD = 64,
    parameter int unsigned TIDW    = 6
) (
    input  logic            gclk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [TIDW-1:0] in_tid,
    input  logic            in_setcc,
    input  logic [31:0]     in_result,
    input  logic            flag_valid,
    input  logic [3:0]      flag_icc,
    input  logic            flag_tag_overflow,
    input  logic            flag_annul,
    input  logic [TIDW-1:0] rd_tid,
    output logic [3:0]      rd_icc,
    output logic            wb_valid,
    output logic [TIDW-1:0] wb_tid,
    output logic [31:0]     wb_result,
    output logic [3:0]      wb_icc,
    output logic            trap_tag_ovf,
    output logic            busy,
    output logic            protocol_err
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TIDW-1:0] r_init_cnt;
    logic            w_init_last;
    logic            w_run;

    logic            r_s1_valid;
    logic [TIDW-1:0] r_s1_tid;
    logic            r_s1_setcc;
    logic [31:0]     r_s1_result;

    logic            w_kill;
    logic            w_commit;
    logic            w_icc_we;
    logic [TIDW-1:0] w_icc_waddr;
    logic [3:0]      w_icc_wdata;
    logic [3:0]      w_rd_data;

    // Distributed RAM, no reset: contents are cleared by the INIT sweep.
    logic [3:0]      r_icc [NTHREAD];

    assign w_init_last = (r_init_cnt == TIDW'(NTHREAD - 1));
    assign w_run       = (r_state == ST_RUN);
    assign busy        = (r_state == ST_INIT);
    assign w_kill      = flag_annul | ~r_s1_valid;
    assign w_commit    = ~w_kill & r_s1_setcc & ~flag_tag_overflow;

    always_ff @(posedge gclk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // ICC file write port: INIT sweep zeroes entries, RUN commits flags; reset suppresses both.
    always_comb begin
        w_icc_we    = 1'b0;
        w_icc_waddr = r_init_cnt;
        w_icc_wdata = 4'b0000;
        case (r_state)
            ST_INIT: w_icc_we = ~rst;
            ST_RUN: begin
                w_icc_we    = ~rst & w_commit;
                w_icc_waddr = r_s1_tid;
                w_icc_wdata = flag_icc;
            end
            default: w_icc_we = 1'b0;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst)        r_init_cnt <= '0;
        else if (busy)  r_init_cnt <= r_init_cnt + TIDW'(1);
    end

    always_ff @(posedge gclk) begin
        if (w_icc_we) r_icc[w_icc_waddr] <= w_icc_wdata;
    end

`ifdef ICC_FWD_EN
    assign w_rd_data = (w_commit && (r_s1_tid == rd_tid)) ? flag_icc : r_icc[rd_tid];
`else
    assign w_rd_data = r_icc[rd_tid];
`endif

    always_ff @(posedge gclk) begin
        if (rst)        rd_icc <= 4'b0000;
        else if (w_run) rd_icc <= w_rd_data;
        else            rd_icc <= 4'b0000;
    end

    // S0 -> S1: valid follows in_valid every cycle, payload only on a valid op.
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_tid    <= '0;
            r_s1_setcc  <= 1'b0;
            r_s1_result <= '0;
        end else begin
            r_s1_valid <= w_run & in_valid;
            if (w_run && in_valid) begin
                r_s1_tid    <= in_tid;
                r_s1_setcc  <= in_setcc;
                r_s1_result <= in_result;
            end
        end
    end

    // S1 -> S2: fallback ICC reads the file after any prior commit to the same thread.
    always_ff @(posedge gclk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_tid       <= '0;
            wb_result    <= '0;
            wb_icc       <= 4'b0000;
            trap_tag_ovf <= 1'b0;
        end else if (w_run) begin
            wb_valid     <= r_s1_valid & ~flag_annul;
            wb_tid       <= r_s1_tid;
            wb_result    <= r_s1_result;
            wb_icc       <= w_commit ? flag_icc : r_icc[r_s1_tid];
            trap_tag_ovf <= r_s1_valid & ~flag_annul & flag_tag_overflow;
        end else begin
            wb_valid     <= 1'b0;
            trap_tag_ovf <= 1'b0;
        end
    end

    always_ff @(posedge gclk) begin
        if (rst)                                   protocol_err <= 1'b0;
        else if (w_run && (flag_valid != r_s1_valid)) protocol_err <= 1'b1;
    end

endmodule

// File: tb/tb_xcv5_icc_commit.sv
// Directed bench for xcv5_icc_commit: op vector table plus init, same-thread and mid-op reset sequences.
module tb_xcv5_icc_commit;

    localparam int unsigned NTHREAD = 64;
    localparam int unsigned TIDW    = 6;

    logic            gclk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [TIDW-1:0] in_tid;
    logic            in_setcc;
    logic [31:0]     in_result;
    logic            flag_valid;
    logic [3:0]      flag_icc;
    logic            flag_tag_overflow;
    logic            flag_annul;
    logic [TIDW-1:0] rd_tid;
    logic [3:0]      rd_icc;
    logic            wb_valid;
    logic [TIDW-1:0] wb_tid;
    logic [31:0]     wb_result;
    logic [3:0]      wb_icc;
    logic            trap_tag_ovf;
    logic            busy;
    logic            protocol_err;

    int n_cmp = 0;
    int n_err = 0;

    xcv5_icc_commit #(.NTHREAD(NTHREAD), .TIDW(TIDW)) dut (
        .gclk              (gclk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_tid            (in_tid),
        .in_setcc          (in_setcc),
        .in_result         (in_result),
        .flag_valid        (flag_valid),
        .flag_icc          (flag_icc),
        .flag_tag_overflow (flag_tag_overflow),
        .flag_annul        (flag_annul),
        .rd_tid            (rd_tid),
        .rd_icc            (rd_icc),
        .wb_valid          (wb_valid),
        .wb_tid            (wb_tid),
        .wb_result         (wb_result),
        .wb_icc            (wb_icc),
        .trap_tag_ovf      (trap_tag_ovf),
        .busy              (busy),
        .protocol_err      (protocol_err)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        logic [TIDW-1:0] tid;
        logic            setcc;
        logic [31:0]     result;
        logic [3:0]      icc;
        logic            tovf;
        logic            annul;
        logic            exp_valid;
        logic [3:0]      exp_icc;
        logic            exp_trap;
        logic [3:0]      exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_tid = '0; in_setcc = 1'b0; in_result = '0;
        flag_valid = 1'b0; flag_icc = 4'b0000; flag_tag_overflow = 1'b0; flag_annul = 1'b0;
    endtask

    // Counts cycles after rst release until busy drops, checking quiet outputs meanwhile.
    task automatic wait_init(input string tag);
        int  n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        while (busy && n < 200) begin
            if (wb_valid !== 1'b0 || rd_icc !== 4'b0000) bad = 1'b1;
            step();
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd64);
        chk({tag, "_quiet_during_init"}, 32'(bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{6'd5,  1'b1, 32'h8000_0000, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 4'b1010};
        vecs[1] = '{6'd3,  1'b1, 32'h0000_0001, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 4'b0100};
        vecs[2] = '{6'd3,  1'b1, 32'h7FFF_FFFF, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100};
        vecs[3] = '{6'd7,  1'b1, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[4] = '{6'd7,  1'b0, 32'hDEAD_BEEF, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000};
        vecs[5] = '{6'd5,  1'b0, 32'h0000_0000, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 4'b1010};
        vecs[6] = '{6'd63, 1'b1, 32'hFFFF_FFFF, 4'b0101, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 4'b0101};
        vecs[7] = '{6'd0,  1'b1, 32'h0000_00A5, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 4'b0011};
        vecs[8] = '{6'd3,  1'b1, 32'h5555_AAAA, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0100};

        rst = 1'b1;
        rd_tid = '0;
        idle_inputs();
        step();
        step();
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_wb_result", wb_result, 32'd0);
        chk("reset_wb_icc", 32'(wb_icc), 32'd0);
        chk("reset_rd_icc", 32'(rd_icc), 32'd0);
        chk("reset_trap", 32'(trap_tag_ovf), 32'd0);
        chk("reset_perr", 32'(protocol_err), 32'd0);

        // Initial sweep, then every entry reads zero.
        rst = 1'b0;
        wait_init("init");
        for (int i = 0; i < int'(NTHREAD); i++) begin
            rd_tid = TIDW'(i);
            step();
            chk($sformatf("init_rd_icc[%0d]", i), 32'(rd_icc), 32'd0);
        end

        // Isolated ops from the vector table.
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1; in_tid = vecs[k].tid; in_setcc = vecs[k].setcc; in_result = vecs[k].result;
            step();
            idle_inputs();
            flag_valid = 1'b1; flag_icc = vecs[k].icc;
            flag_tag_overflow = vecs[k].tovf; flag_annul = vecs[k].annul;
            rd_tid = vecs[k].tid;
            step();
            idle_inputs();
            chk($sformatf("v%0d_wb_valid", k), 32'(wb_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("v%0d_wb_icc", k), 32'(wb_icc), 32'(vecs[k].exp_icc));
            chk($sformatf("v%0d_trap", k), 32'(trap_tag_ovf), 32'(vecs[k].exp_trap));
            if (vecs[k].exp_valid) begin
                chk($sformatf("v%0d_wb_result", k), wb_result, vecs[k].result);
                chk($sformatf("v%0d_wb_tid", k), 32'(wb_tid), 32'(vecs[k].tid));
            end
            step();
            chk($sformatf("v%0d_rd_icc", k), 32'(rd_icc), 32'(vecs[k].exp_rd));
            chk($sformatf("v%0d_wb_valid_drop", k), 32'(wb_valid), 32'd0);
            chk($sformatf("v%0d_perr", k), 32'(protocol_err), 32'd0);
        end

        // Back-to-back same thread: A commits 0001, B (no setcc) must see it.
        in_valid = 1'b1; in_tid = 6'd9; in_setcc = 1'b1; in_result = 32'hAAAA_0001;
        step();
        in_valid = 1'b1; in_tid = 6'd9; in_setcc = 1'b0; in_result = 32'hBBBB_0002;
        flag_valid = 1'b1; flag_icc = 4'b0001; rd_tid = 6'd9;
        step();
        in_valid = 1'b0; flag_valid = 1'b1; flag_icc = 4'b1110;
        chk("b2b_A_wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b_A_wb_icc", 32'(wb_icc), 32'b0001);
        chk("b2b_A_wb_result", wb_result, 32'hAAAA_0001);
`ifdef ICC_FWD_EN
        chk("b2b_rd_icc_commit_cycle", 32'(rd_icc), 32'b0001);
`else
        chk("b2b_rd_icc_commit_cycle", 32'(rd_icc), 32'b0000);
`endif
        step();
        idle_inputs();
        chk("b2b_B_wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b_B_wb_icc", 32'(wb_icc), 32'b0001);
        chk("b2b_B_wb_result", wb_result, 32'hBBBB_0002);
        chk("b2b_rd_icc_after", 32'(rd_icc), 32'b0001);
        step();
        chk("b2b_perr", 32'(protocol_err), 32'd0);

        // Flags without an op in S1 set the sticky protocol error.
        flag_valid = 1'b1;
        step();
        flag_valid = 1'b0;
        chk("perr_set", 32'(protocol_err), 32'd1);
        step();
        step();
        chk("perr_sticky", 32'(protocol_err), 32'd1);

        // Reset lands while an op sits in S1.
        in_valid = 1'b1; in_tid = 6'd11; in_setcc = 1'b1; in_result = 32'hCAFE_F00D;
        step();
        idle_inputs();
        flag_valid = 1'b1; flag_icc = 4'b1111; rd_tid = 6'd11;
        rst = 1'b1;
        step();
        idle_inputs();
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_perr", 32'(protocol_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_init("midrst");
        step();
        chk("midrst_rd_icc11", 32'(rd_icc), 32'd0);
        chk("midrst_wb_after", 32'(wb_valid), 32'd0);
        rd_tid = 6'd5;
        step();
        chk("midrst_rd_icc5_cleared", 32'(rd_icc), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xcv5_icc_commit.md
Name: xcv5_icc_commit

Overview:
- Downstream of the Virtex-5 DSP adder/logic ALU. Consumes the ALU result (valid in cycle 0) and the flags/tag-overflow (valid in cycle 1).
- Aligns both, commits integer condition codes (ICC: N,Z,V,C) into a per-thread ICC file, raises tag-overflow traps, and presents an aligned writeback record.
- Provides a registered ICC read port for the issue stage. Clears the ICC file after reset with a walking init FSM.

Parameters:
NTHREAD, 64, number of hardware threads / ICC file depth (power of 2)
TIDW, 6, thread-id width, log2(NTHREAD)

Ports:
gclk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  cycle-0 ALU op valid
in_tid  input  TIDW  cycle-0 thread id
in_setcc  input  1  cycle-0: op writes ICC
in_result  input  32  cycle-0 raw ALU result
flag_valid  input  1  cycle-1 ALU output valid
flag_icc  input  4  cycle-1 {N,Z,V,C}
flag_tag_overflow  input  1  cycle-1 TADDccTV/TSUBccTV overflow
flag_annul  input  1  cycle-1 kill of the op now in S1
rd_tid  input  TIDW  ICC read address
rd_icc  output  4  ICC of rd_tid, one cycle later
wb_valid  output  1  writeback record valid
wb_tid  output  TIDW  writeback thread id
wb_result  output  32  writeback result
wb_icc  output  4  ICC value after this op
trap_tag_ovf  output  1  tag-overflow trap for wb_tid
busy  output  1  init FSM clearing ICC file
protocol_err  output  1  sticky: flag_valid disagrees with S1 valid

Behaviour:
- FSM states: INIT, RUN.
- rst forces INIT with init_cnt=0. This applies at any time, including mid-operation: in-flight S1/S2 contents are discarded.
- INIT:
  - Writes ICC[init_cnt]=4'b0 and increments init_cnt each cycle.
  - After writing entry NTHREAD-1, goes to RUN. INIT takes exactly NTHREAD cycles after rst deasserts.
  - busy=1 throughout INIT. in_valid is ignored and no wb is produced. rd_icc returns 0.
- RUN, S0->S1 register:
  - On every edge, s1_valid <= in_valid.
  - s1_tid, s1_setcc and s1_result are captured when in_valid=1.
- RUN, S1 (flags cycle):
  - kill = flag_annul | !s1_valid.
  - commit = !kill & s1_setcc & !flag_tag_overflow. When commit is true, ICC[s1_tid] <= flag_icc.
  - A trapping TADDccTV/TSUBccTV (flag_tag_overflow=1) does not modify ICC.
  - protocol_err sets when flag_valid != s1_valid. It clears only on rst.
- RUN, S1->S2 output register:
  - wb_valid <= s1_valid & !flag_annul.
  - wb_tid/wb_result <= s1 values.
  - wb_icc <= flag_icc if commit, else ICC[s1_tid] (old value).
  - trap_tag_ovf <= s1_valid & !flag_annul & flag_tag_overflow.
- Latency: in_valid at cycle t -> wb_valid at t+2. Flags at t+1. Throughput: one op per cycle, back-to-back across any thread mix.
- Read port: rd_icc <= ICC[rd_tid] on each edge; the read latency is 1.
- Same-thread consecutive ops: the second op's wb_icc fallback reads the ICC file after the first commit. The file write and the S2 read are ordered so that the first op's commit is visible.
- Reset values: rd_icc=0, wb_valid=0, wb_tid=0, wb_result=0, wb_icc=0, trap_tag_ovf=0, busy=1, protocol_err=0.
- The ICC file is distributed RAM (no bulk reset); the INIT sweep is mandatory.

Optional Feature:
- Macro ICC_FWD_EN.
- Defined: when a commit to thread X occurs in the same cycle that rd_tid==X is sampled, rd_icc returns the newly committed flag_icc (write-first bypass).
- Undefined: rd_icc returns the pre-write value (read-first). The issue stage must then guarantee the same thread is not read in the commit cycle. Saves 4 LUTs plus the comparator.

Test Plan:
- Reset/init: pulse rst 1 cycle, NTHREAD=64 -> busy high exactly 64 cycles. Then rd_icc=0 for rd_tid 0..63. wb_valid stays 0 throughout.
- ADDcc commit: tid=5, setcc=1, result 0x80000000, flags N=1,Z=0,V=1,C=0 in cycle 1 -> wb_valid=1 at t+2, wb_result=0x80000000, wb_icc=4'b1010. rd_tid=5 next cycle -> rd_icc=4'b1010.
- Tag trap: TADDccTV on tid=3 with ICC[3]=4'b0100, flag_tag_overflow=1, flag_icc=4'b0010 -> trap_tag_ovf=1, wb_icc=4'b0100, ICC[3] unchanged.
- Annul and non-cc op:
  - Annul case: flag_annul=1 on tid=7 setcc -> wb_valid=0, ICC[7] unchanged.
  - Non-cc case: setcc=0 -> wb_icc=old ICC, no write.
- Back-to-back same thread: tid=9 op A flags 4'b0001 then op B setcc=0 next cycle -> B's wb_icc=4'b0001. With ICC_FWD_EN, rd_tid=9 sampled in A's commit cycle -> rd_icc=4'b0001 (without: old value 0).
- Mid-op reset: rst asserted while an op is in S1 -> no wb_valid, no ICC write, protocol_err=0, busy=1 for 64 cycles.
